// File: rtl/enigma_pkg.sv
// Shared types for the rotor stepping controller: position type, packed rotor triple and FSM state.
// Default alphabet size and the home position are also defined here.
package enigma_pkg;

    localparam int LETTERS_DEF = 26;

    typedef logic [6:0] pos_t;

    // r1 occupies the low bits so the packing matches cfg_pos_i / dp_pos_o.
    typedef struct packed {
        pos_t r3;
        pos_t r2;
        pos_t r1;
    } rotor_pos_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } step_state_e;

    localparam rotor_pos_t POS_HOME = '{r3: 7'd1, r2: 7'd1, r1: 7'd1};

    function automatic logic pos_ok(input pos_t p, input pos_t last);
        return (p != '0) && (p <= last);
    endfunction

endpackage

// File: rtl/enigma_pos_inc.sv
// Single-rotor wrap increment: LETTERS goes to 1, otherwise +1; out-of-range inputs also land on 1.
// Purely combinational, zero latency, no handshake.
module enigma_pos_inc
    import enigma_pkg::*;
#(
    parameter int LETTERS = LETTERS_DEF
) (
    input  pos_t pos_i,
    input  logic step_i,
    output pos_t pos_o
);

    localparam pos_t LAST = pos_t'(LETTERS);

    always_comb begin
        pos_o = pos_i;
        if (step_i) begin
            if ((pos_i >= LAST) || (pos_i == '0)) begin
                pos_o = pos_t'(1);
            end else begin
                pos_o = pos_i + pos_t'(1);
            end
        end
    end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Rotor step controller: accepts a symbol, steps rotors, issues one strobe DP_LAT+2 cycles of busy.
// in_rdy_o low outside IDLE and while cfg_val_i is high; STEP_CTRL_DOUBLE_STEP_EN enables the middle-rotor double step.
module enigma_step_ctrl
    import enigma_pkg::*;
#(
    parameter int LETTERS  = LETTERS_DEF,
    parameter int NOTCH_R1 = 17,
    parameter int NOTCH_R2 = 5,
    parameter int DP_LAT   = 5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_val_i,
    input  logic [20:0] cfg_pos_i,
    input  logic        in_val_i,
    output logic        in_rdy_o,
    input  logic [6:0]  in_symb_i,
    output logic        dp_val_o,
    output logic [6:0]  dp_symb_o,
    output logic [20:0] dp_pos_o,
    output logic        busy_o,
    output logic        cfg_err_o
);

    localparam pos_t       LAST_P   = pos_t'(LETTERS);
    localparam pos_t       NOTCH1_P = pos_t'(NOTCH_R1);
    localparam pos_t       NOTCH2_P = pos_t'(NOTCH_R2);
    localparam logic [3:0] LAT_P    = 4'(DP_LAT);

    step_state_e state_q, state_d;
    rotor_pos_t  pos_q, pos_d;
    rotor_pos_t  dp_pos_q, dp_pos_d;
    pos_t        symb_q, symb_d;
    pos_t        dp_symb_q, dp_symb_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dp_val_q, dp_val_d;
    logic        cfg_err_q, cfg_err_d;

    rotor_pos_t  cfg_pos;
    rotor_pos_t  cfg_clean;
    rotor_pos_t  pos_step;
    logic        cfg_bad;
    logic        r2_step;
    logic        r3_step;

    assign cfg_pos = rotor_pos_t'(cfg_pos_i);

    always_comb begin
        cfg_clean.r1 = pos_ok(cfg_pos.r1, LAST_P) ? cfg_pos.r1 : pos_t'(1);
        cfg_clean.r2 = pos_ok(cfg_pos.r2, LAST_P) ? cfg_pos.r2 : pos_t'(1);
        cfg_clean.r3 = pos_ok(cfg_pos.r3, LAST_P) ? cfg_pos.r3 : pos_t'(1);
        cfg_bad      = !pos_ok(cfg_pos.r1, LAST_P) || !pos_ok(cfg_pos.r2, LAST_P)
                    || !pos_ok(cfg_pos.r3, LAST_P);
    end

    // The slow rotor advances only when the middle rotor actually leaves its notch,
    // which in odometer mode additionally needs the fast rotor to carry.
`ifdef STEP_CTRL_DOUBLE_STEP_EN
    assign r2_step = (pos_q.r1 == NOTCH1_P) || (pos_q.r2 == NOTCH2_P);
    assign r3_step = (pos_q.r2 == NOTCH2_P);
`else
    assign r2_step = (pos_q.r1 == NOTCH1_P);
    assign r3_step = r2_step && (pos_q.r2 == NOTCH2_P);
`endif

    enigma_pos_inc #(.LETTERS(LETTERS)) u_inc_r1 (
        .pos_i  (pos_q.r1),
        .step_i (1'b1),
        .pos_o  (pos_step.r1)
    );

    enigma_pos_inc #(.LETTERS(LETTERS)) u_inc_r2 (
        .pos_i  (pos_q.r2),
        .step_i (r2_step),
        .pos_o  (pos_step.r2)
    );

    enigma_pos_inc #(.LETTERS(LETTERS)) u_inc_r3 (
        .pos_i  (pos_q.r3),
        .step_i (r3_step),
        .pos_o  (pos_step.r3)
    );

    // Configuration has priority over a symbol offered in the same IDLE cycle.
    assign in_rdy_o = (state_q == IDLE) && !cfg_val_i;

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        dp_pos_d  = dp_pos_q;
        symb_d    = symb_q;
        dp_symb_d = dp_symb_q;
        cnt_d     = cnt_q;
        dp_val_d  = 1'b0;
        cfg_err_d = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (cfg_val_i) begin
                    pos_d = cfg_clean;
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end
                end else if (in_val_i) begin
                    symb_d  = in_symb_i;
                    state_d = STEP;
                end
            end
            STEP: begin
                pos_d     = pos_step;
                dp_pos_d  = pos_step;
                dp_symb_d = symb_q;
                dp_val_d  = 1'b1;
                state_d   = ISSUE;
            end
            ISSUE: begin
                cnt_d   = LAT_P;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            pos_q     <= POS_HOME;
            dp_pos_q  <= POS_HOME;
            symb_q    <= '0;
            dp_symb_q <= '0;
            cnt_q     <= '0;
            dp_val_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            dp_pos_q  <= dp_pos_d;
            symb_q    <= symb_d;
            dp_symb_q <= dp_symb_d;
            cnt_q     <= cnt_d;
            dp_val_q  <= dp_val_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign dp_val_o  = dp_val_q;
    assign dp_symb_o = dp_symb_q;
    assign dp_pos_o  = dp_pos_q;
    assign busy_o    = (state_q != IDLE);
    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed bench for enigma_step_ctrl: table of cfg/symbol vectors plus hand-written corner sequences.
module tb_enigma_step_ctrl;

    localparam int DP_LAT = 5;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cfg_val_i;
    logic [20:0] cfg_pos_i;
    logic        in_val_i;
    logic        in_rdy_o;
    logic [6:0]  in_symb_i;
    logic        dp_val_o;
    logic [6:0]  dp_symb_o;
    logic [20:0] dp_pos_o;
    logic        busy_o;
    logic        cfg_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    enigma_step_ctrl #(
        .LETTERS  (26),
        .NOTCH_R1 (17),
        .NOTCH_R2 (5),
        .DP_LAT   (DP_LAT)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .cfg_val_i (cfg_val_i),
        .cfg_pos_i (cfg_pos_i),
        .in_val_i  (in_val_i),
        .in_rdy_o  (in_rdy_o),
        .in_symb_i (in_symb_i),
        .dp_val_o  (dp_val_o),
        .dp_symb_o (dp_symb_o),
        .dp_pos_o  (dp_pos_o),
        .busy_o    (busy_o),
        .cfg_err_o (cfg_err_o)
    );

    typedef struct {
        int c3, c2, c1;
        int symb;
        int e3, e2, e1;
        int eerr;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input int c3, input int c2, input int c1, input int symb,
                                input int e3, input int e2, input int e1, input int eerr);
        vec_t v;
        v.c3 = c3; v.c2 = c2; v.c1 = c1; v.symb = symb;
        v.e3 = e3; v.e2 = e2; v.e1 = e1; v.eerr = eerr;
        return v;
    endfunction

    function automatic int pk(input int r3, input int r2, input int r1);
        return (r3 << 14) | (r2 << 7) | r1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_cfg(input int c3, input int c2, input int c1);
        cfg_val_i = 1'b1;
        cfg_pos_i = 21'(pk(c3, c2, c1));
        tick;
        cfg_val_i = 1'b0;
        cfg_pos_i = '0;
    endtask

    // Offers one symbol and watches the following cycles: first strobe cycle, strobe count,
    // captured position/symbol and the cycle in_rdy_o returns.
    task automatic send_sym(input string tag, input int s, output int pos_seen, output int symb_seen,
                            output int val_k, output int val_n, output int rdy_k);
        in_val_i  = 1'b1;
        in_symb_i = 7'(s);
        #1;
        check({tag, "_rdy_before"}, int'(in_rdy_o), 1);
        tick;
        in_val_i  = 1'b0;
        pos_seen  = -1;
        symb_seen = -1;
        val_k     = 0;
        val_n     = 0;
        rdy_k     = 0;
        for (int k = 1; k <= DP_LAT + 4; k++) begin
            tick;
            if (dp_val_o) begin
                val_n++;
                if (val_k == 0) begin
                    val_k     = k;
                    pos_seen  = int'(dp_pos_o);
                    symb_seen = int'(dp_symb_o);
                end
            end
            if (in_rdy_o && rdy_k == 0) begin
                rdy_k = k;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pos, sy, vk, vn, rk;
        int cnt_val, cnt_busy;
        string t;

        vecs[0] = mk( 1,  1,  1, 65,  1, 1,  2, 0);
        vecs[1] = mk( 1,  1, 17, 66,  1, 2, 18, 0);
        vecs[2] = mk( 1,  1, 26, 67,  1, 1,  1, 0);
`ifdef STEP_CTRL_DOUBLE_STEP_EN
        vecs[3] = mk(26,  5,  3, 68,  1, 6,  4, 0);
`else
        vecs[3] = mk(26,  5,  3, 68, 26, 5,  4, 0);
`endif
        vecs[4] = mk(10,  5, 17, 69, 11, 6, 18, 0);
        vecs[5] = mk(26, 26, 17, 70, 26, 1, 18, 0);
        vecs[6] = mk( 1,  1,  0, 71,  1, 1,  2, 1);
        vecs[7] = mk(27,  0, 40, 72,  1, 1,  2, 1);

        rst_n_i   = 1'b0;
        cfg_val_i = 1'b0;
        cfg_pos_i = '0;
        in_val_i  = 1'b0;
        in_symb_i = '0;
        repeat (2) tick;
        check("rst_dp_val",  int'(dp_val_o),  0);
        check("rst_dp_pos",  int'(dp_pos_o),  pk(1, 1, 1));
        check("rst_dp_symb", int'(dp_symb_o), 0);
        check("rst_busy",    int'(busy_o),    0);
        check("rst_cfg_err", int'(cfg_err_o), 0);
        rst_n_i = 1'b1;
        tick;
        check("rst_in_rdy", int'(in_rdy_o), 1);

        for (int i = 0; i < 8; i++) begin
            t = $sformatf("v%0d", i);
            load_cfg(vecs[i].c3, vecs[i].c2, vecs[i].c1);
            check({t, "_cfg_err"}, int'(cfg_err_o), vecs[i].eerr);
            send_sym(t, vecs[i].symb, pos, sy, vk, vn, rk);
            check({t, "_val_cycle"}, vk, 1);
            check({t, "_val_count"}, vn, 1);
            check({t, "_dp_pos"}, pos, pk(vecs[i].e3, vecs[i].e2, vecs[i].e1));
            check({t, "_dp_symb"}, sy, vecs[i].symb);
            check({t, "_rdy_latency"}, rk, DP_LAT + 2);
            check({t, "_pos_hold"}, int'(dp_pos_o), pk(vecs[i].e3, vecs[i].e2, vecs[i].e1));
        end

        // Two symbols across the middle-rotor notch.
        load_cfg(1, 4, 17);
        send_sym("dbl1", 80, pos, sy, vk, vn, rk);
        check("dbl1_dp_pos", pos, pk(1, 5, 18));
        send_sym("dbl2", 81, pos, sy, vk, vn, rk);
`ifdef STEP_CTRL_DOUBLE_STEP_EN
        check("dbl2_dp_pos", pos, pk(2, 6, 19));
`else
        check("dbl2_dp_pos", pos, pk(1, 5, 19));
`endif

        // cfg and symbol offered together: cfg loads, symbol is refused.
        cfg_val_i = 1'b1;
        cfg_pos_i = 21'(pk(3, 3, 3));
        in_val_i  = 1'b1;
        in_symb_i = 7'h42;
        #1;
        check("both_in_rdy", int'(in_rdy_o), 0);
        tick;
        cfg_val_i = 1'b0;
        in_val_i  = 1'b0;
        cnt_val   = 0;
        cnt_busy  = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (dp_val_o) cnt_val++;
            if (busy_o) cnt_busy++;
        end
        check("both_no_strobe", cnt_val, 0);
        check("both_no_busy", cnt_busy, 0);
        send_sym("both_after", 67, pos, sy, vk, vn, rk);
        check("both_after_dp_pos", pos, pk(3, 3, 4));
        check("both_after_symb", sy, 67);

        // cfg pulsed during WAIT must be ignored.
        in_val_i  = 1'b1;
        in_symb_i = 7'h44;
        tick;
        in_val_i = 1'b0;
        repeat (3) tick;
        check("wait_busy", int'(busy_o), 1);
        load_cfg(10, 10, 10);
        repeat (6) tick;
        check("wait_back_idle", int'(in_rdy_o), 1);
        check("wait_pos_hold", int'(dp_pos_o), pk(3, 3, 5));
        send_sym("wait_after", 69, pos, sy, vk, vn, rk);
        check("wait_after_dp_pos", pos, pk(3, 3, 6));

        // Reset during WAIT abandons the symbol and clears the sticky error.
        in_val_i  = 1'b1;
        in_symb_i = 7'h50;
        tick;
        in_val_i = 1'b0;
        repeat (3) tick;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midrst_dp_val",  int'(dp_val_o),  0);
        check("midrst_dp_pos",  int'(dp_pos_o),  pk(1, 1, 1));
        check("midrst_dp_symb", int'(dp_symb_o), 0);
        check("midrst_busy",    int'(busy_o),    0);
        check("midrst_cfg_err", int'(cfg_err_o), 0);
        tick;
        rst_n_i = 1'b1;
        cnt_val = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (dp_val_o) cnt_val++;
        end
        check("midrst_no_strobe", cnt_val, 0);
        check("midrst_in_rdy", int'(in_rdy_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
